// File: rtl/hazard_pkg.sv
// Shared widths, constants and MD FSM encoding for the hazard controller.
package hazard_pkg;

   localparam int TWIDTH = 2;
   localparam logic [TWIDTH-1:0] TUSE_UNUSED = 2'd3;
   localparam int CNT_W = 4;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_e;

endpackage

// File: rtl/md_busy_timer.sv
// Multiply/divide busy timer: loads the operation latency on start and counts down.
// MULT_LAT and DIV_LAT must both lie in 1..15 to fit the counter.
module md_busy_timer
   import hazard_pkg::*;
#(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic start_i,
   input  logic div_i,
   output logic busy_o
);

   localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
   localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= MD_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // A start arriving while already busy is dropped; the running operation owns the unit.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         MD_IDLE: begin
            if (start_i) begin
               state_d = MD_BUSY;
               cnt_d   = div_i ? DIV_CNT : MULT_CNT;
            end
         end
         MD_BUSY: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = MD_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = MD_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign busy_o = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: Tuse/Tnew data-hazard stalls plus MD-unit stalls.
// Optional macro HAZARD_PERF_EN adds a saturating stalled-cycle counter.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [4:0]        d_rs_addr,
   input  logic [4:0]        d_rt_addr,
   input  logic [TWIDTH-1:0] d_rs_tuse,
   input  logic [TWIDTH-1:0] d_rt_tuse,
   input  logic [4:0]        e_wr_addr,
   input  logic [4:0]        m_wr_addr,
   input  logic [TWIDTH-1:0] e_tnew,
   input  logic [TWIDTH-1:0] m_tnew,
   input  logic              d_is_md,
   input  logic              e_md_start,
   input  logic              e_md_div,
   output logic              pc_freeze,
   output logic              d_en,
   output logic              e_flush,
   output logic              md_busy,
   output logic [31:0]       stall_cnt
);

   logic rs_e_hz, rt_e_hz, rs_m_hz, rt_m_hz;
   logic stall_md, stall;

   md_busy_timer #(
      .MULT_LAT(MULT_LAT),
      .DIV_LAT (DIV_LAT)
   ) u_md_timer (
      .clk    (clk),
      .reset  (reset),
      .start_i(e_md_start),
      .div_i  (e_md_div),
      .busy_o (md_busy)
   );

   // r0 never carries a dependency, so a zero source address cannot match a producer.
   assign rs_e_hz = (d_rs_addr != 5'd0) && (d_rs_addr == e_wr_addr) && (d_rs_tuse < e_tnew);
   assign rt_e_hz = (d_rt_addr != 5'd0) && (d_rt_addr == e_wr_addr) && (d_rt_tuse < e_tnew);
   assign rs_m_hz = (d_rs_addr != 5'd0) && (d_rs_addr == m_wr_addr) && (d_rs_tuse < m_tnew);
   assign rt_m_hz = (d_rt_addr != 5'd0) && (d_rt_addr == m_wr_addr) && (d_rt_tuse < m_tnew);

   assign stall_md = d_is_md && (md_busy || e_md_start);
   assign stall    = rs_e_hz || rt_e_hz || rs_m_hz || rt_m_hz || stall_md;

   assign pc_freeze = stall;
   assign d_en      = !stall;
   assign e_flush   = stall;

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`else
   assign stall_cnt = '0;
`endif

endmodule
